packet_assembler_bch: RTL and testbench

// - Second-generation HDMI data-island packet assembler. Accepts whole packets (24b header + 4x56b

---
 rtl/packet_assembler_bch.sv | 155 +++++++++++++++
 tb/tb_packet_assembler_bch.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/packet_assembler_bch.sv
// HDMI data-island packet assembler: one-deep pending buffer, 32-cycle serialisation of
// header + 4 subpackets, serial BCH parity appended per channel, null fill and abort.

module packet_assembler_bch_lane #(
    parameter bit         ECC_EN   = 1'b1,
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic        run,
    input  logic [4:0]  cnt,
    input  logic [55:0] sub,
    output logic [1:0]  bits
);
    logic [7:0] ecc_q, e_base, e_mid;
    logic       d_even, d_odd;

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic d);
        return {1'b0, e[7:1]} ^ ((e[0] ^ d) ? ECC_POLY : 8'h00);
    endfunction

    // Shifts past bit 55 (cnt >= 28) yield 0, so no range guard is needed here
    assign d_even = |(sub & (56'd1 << {cnt, 1'b0}));
    assign d_odd  = |(sub & (56'd2 << {cnt, 1'b0}));
    assign e_base = (cnt == 5'd0) ? 8'h00 : ecc_q;
    assign e_mid  = bch_step(e_base, d_even);

    always_comb begin
        bits = {d_odd, d_even};
        if (cnt >= 5'd28) begin
            bits = 2'b00;
            if (ECC_EN)
                bits = {|(ecc_q & (8'd2 << {cnt[1:0], 1'b0})),
                        |(ecc_q & (8'd1 << {cnt[1:0], 1'b0}))};
        end
    end

    always_ff @(posedge clk_pixel) begin
        if (!rst_n || !run)
            ecc_q <= 8'h00;
        else if (cnt < 5'd28)
            ecc_q <= bch_step(e_mid, d_odd);
    end
endmodule

module packet_assembler_bch #(
    parameter bit         ECC_EN   = 1'b1,
    parameter logic [7:0] ECC_POLY = 8'h83,
    parameter int         NUM_SUB  = 4
) (
    input  logic                    clk_pixel,
    input  logic                    rst_n,
    input  logic                    island_active,
    input  logic                    pkt_valid,
    output logic                    pkt_ready,
    input  logic [23:0]             pkt_header,
    input  logic [NUM_SUB-1:0][55:0] pkt_sub,
    output logic                    ch0_hdr_bit,
    output logic                    ch0_not_first,
    output logic [NUM_SUB-1:0]      ch1_data,
    output logic [NUM_SUB-1:0]      ch2_data,
    output logic                    out_valid,
    output logic                    pkt_done,
    output logic                    pkt_abort
);
    localparam int STAGES = 0;

    typedef struct packed {
        logic [23:0]              hdr;
        logic [NUM_SUB-1:0][55:0] sub;
    } pkt_t;

    pkt_t                      pend_q, active_q, cur;
    logic                      pend_full, pend_full_nxt, hs, load, abort_now;
    logic [4:0]                cnt;
    logic [7:0]                hdr_ecc, hdr_e_base;
    logic                      hdr_d, hdr_bit;
    logic [STAGES:0]           vld_pipe;
    logic [NUM_SUB-1:0][1:0]   lane_bits;

    if (NUM_SUB != 4) begin : g_bad_num_sub
        $error("packet_assembler_bch: NUM_SUB must be 4");
    end

    function automatic logic [7:0] bch_step(input logic [7:0] e, input logic d);
        return {1'b0, e[7:1]} ^ ((e[0] ^ d) ? ECC_POLY : 8'h00);
    endfunction

    assign load          = island_active && (cnt == 5'd0);
    assign abort_now     = !island_active && (cnt != 5'd0);
    assign hs            = pkt_valid && pkt_ready;
    assign pend_full_nxt = (pend_full && !load) || hs;
    // At cnt 0 the packet being loaded is already serialised, so bypass active_q
    assign cur           = load ? (pend_full ? pend_q : '0) : active_q;

    assign hdr_e_base = (cnt == 5'd0) ? 8'h00 : hdr_ecc;
    assign hdr_d      = |(cur.hdr & (24'd1 << cnt));
    assign hdr_bit    = (cnt < 5'd24) ? hdr_d
                                      : (ECC_EN && |(hdr_ecc & (8'd1 << cnt[2:0])));
    assign out_valid  = vld_pipe[STAGES];

    for (genvar k = 0; k < NUM_SUB; k++) begin : g_lane
        packet_assembler_bch_lane #(.ECC_EN(ECC_EN), .ECC_POLY(ECC_POLY)) u_lane (
            .clk_pixel (clk_pixel),
            .rst_n     (rst_n),
            .run       (island_active),
            .cnt       (cnt),
            .sub       (cur.sub[k]),
            .bits      (lane_bits[k])
        );
    end

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            cnt           <= 5'd0;
            pend_q        <= '0;
            pend_full     <= 1'b0;
            pkt_ready     <= 1'b0;
            active_q      <= '0;
            hdr_ecc       <= 8'h00;
            vld_pipe      <= '0;
            ch0_hdr_bit   <= 1'b0;
            ch0_not_first <= 1'b0;
            ch1_data      <= '0;
            ch2_data      <= '0;
            pkt_done      <= 1'b0;
            pkt_abort     <= 1'b0;
        end else begin
            cnt       <= island_active ? cnt + 5'd1 : 5'd0;
            pend_full <= pend_full_nxt;
            pkt_ready <= !pend_full_nxt;
            if (hs) begin
                pend_q.hdr <= pkt_header;
                pend_q.sub <= pkt_sub;
            end
            if (load)
                active_q <= cur;
            else if (abort_now)
                active_q <= '0;
            if (!island_active)
                hdr_ecc <= 8'h00;
            else if (cnt < 5'd24)
                hdr_ecc <= bch_step(hdr_e_base, hdr_d);
            vld_pipe[0]   <= island_active;
            ch0_hdr_bit   <= island_active && hdr_bit;
            ch0_not_first <= island_active && (cnt != 5'd0);
            for (int k = 0; k < NUM_SUB; k++) begin
                ch1_data[k] <= island_active && lane_bits[k][0];
                ch2_data[k] <= island_active && lane_bits[k][1];
            end
            pkt_done  <= island_active && (cnt == 5'd31);
            pkt_abort <= abort_now;
        end
    end
endmodule

// File: tb/tb_packet_assembler_bch.sv
// Scoreboard bench for packet_assembler_bch: directed packets, ECC on and off instances.

module tb_packet_assembler_bch;
    logic             clk_pixel = 1'b0;
    logic             rst_n = 1'b0;
    logic             island_active = 1'b0;
    logic             pkt_valid = 1'b0;
    logic [23:0]      pkt_header = '0;
    logic [3:0][55:0] pkt_sub = '0;

    logic pkt_ready, ch0_hdr_bit, ch0_not_first, out_valid, pkt_done, pkt_abort;
    logic [3:0] ch1_data, ch2_data;
    logic pkt_ready0, ch0_hdr_bit0, ch0_not_first0, out_valid0, pkt_done0, pkt_abort0;
    logic [3:0] ch1_data0, ch2_data0;

    packet_assembler_bch u_dut (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .island_active(island_active),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_header(pkt_header),
        .pkt_sub(pkt_sub), .ch0_hdr_bit(ch0_hdr_bit), .ch0_not_first(ch0_not_first),
        .ch1_data(ch1_data), .ch2_data(ch2_data), .out_valid(out_valid),
        .pkt_done(pkt_done), .pkt_abort(pkt_abort));

    packet_assembler_bch #(.ECC_EN(1'b0)) u_dut0 (
        .clk_pixel(clk_pixel), .rst_n(rst_n), .island_active(island_active),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready0), .pkt_header(pkt_header),
        .pkt_sub(pkt_sub), .ch0_hdr_bit(ch0_hdr_bit0), .ch0_not_first(ch0_not_first0),
        .ch1_data(ch1_data0), .ch2_data(ch2_data0), .out_valid(out_valid0),
        .pkt_done(pkt_done0), .pkt_abort(pkt_abort0));

    always #5 clk_pixel = ~clk_pixel;

    typedef struct {
        logic [23:0]      h;
        logic [3:0][55:0] s;
    } pkt_t;

    logic [10:0] exp_q[$], exp0_q[$];
    pkt_t        offer_q[$], isl_q[$];
    int          n_pass = 0, n_chk = 0, exp_aborts = 0;
    logic [10:0] e1, e0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, req);
    endtask

    function automatic logic [7:0] ref_bch(input logic [55:0] v, input int len);
        logic [7:0] e;
        logic       fb;
        e = 8'h00;
        for (int i = 0; i < len; i++) begin
            fb = e[0] ^ v[i];
            e  = (e >> 1) ^ (fb ? 8'h83 : 8'h00);
        end
        return e;
    endfunction

    // Expected {pkt_done, ch0_not_first, ch0_hdr_bit, ch2, ch1} for cycle n of packet p
    function automatic logic [10:0] ref_cycle(input pkt_t p, input int n, input bit en);
        logic [7:0] he, se;
        logic       h;
        logic [3:0] c1, c2;
        he = ref_bch({32'h0, p.h}, 24);
        h  = (n < 24) ? p.h[n] : (en ? he[n-24] : 1'b0);
        for (int k = 0; k < 4; k++) begin
            if (n < 28) begin
                c1[k] = p.s[k][2*n];
                c2[k] = p.s[k][2*n+1];
            end else begin
                se    = ref_bch(p.s[k], 56);
                c1[k] = en ? se[2*(n-28)]   : 1'b0;
                c2[k] = en ? se[2*(n-28)+1] : 1'b0;
            end
        end
        return {(n == 31), (n != 0), h, c2, c1};
    endfunction

    task automatic present();
        if (offer_q.size() > 0) begin
            pkt_valid  = 1'b1;
            pkt_header = offer_q[0].h;
            pkt_sub    = offer_q[0].s;
        end else begin
            pkt_valid = 1'b0;
        end
    endtask

    task automatic tick();
        logic hs;
        hs = pkt_valid && pkt_ready;
        @(posedge clk_pixel);
        #1;
        if (hs) void'(offer_q.pop_front());
        present();
    endtask

    task automatic island(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            island_active = 1'b1;
            exp_q.push_back(ref_cycle(isl_q[i/32], i % 32, 1'b1));
            exp0_q.push_back(ref_cycle(isl_q[i/32], i % 32, 1'b0));
            tick();
        end
        island_active = 1'b0;
    endtask

    function automatic pkt_t mk(input logic [23:0] h, input logic [55:0] s0,
                                input logic [55:0] s1, input logic [55:0] s2,
                                input logic [55:0] s3);
        pkt_t p;
        p.h = h;
        p.s[0] = s0; p.s[1] = s1; p.s[2] = s2; p.s[3] = s3;
        return p;
    endfunction

    always @(negedge clk_pixel) begin
        if (out_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                e1 = exp_q.pop_front();
                chk("ecc_on_out", {pkt_done, ch0_not_first, ch0_hdr_bit, ch2_data, ch1_data}, e1);
            end
        end else
            chk("idle_zero", {pkt_done, ch0_not_first, ch0_hdr_bit, ch2_data, ch1_data}, 0);
        if (out_valid0) begin
            if (exp0_q.size() == 0) chk("unexpected_valid_noecc", 1, 0);
            else begin
                e0 = exp0_q.pop_front();
                chk("ecc_off_out", {pkt_done0, ch0_not_first0, ch0_hdr_bit0, ch2_data0, ch1_data0}, e0);
            end
        end
        if (pkt_abort) begin
            chk("abort_expected", exp_aborts > 0, 1);
            chk("abort_out_valid", out_valid, 0);
            if (exp_aborts > 0) exp_aborts--;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        pkt_t pn, p_h1, p_s2, pa, pb, px, py;
        pn   = mk(24'h0, 56'h0, 56'h0, 56'h0, 56'h0);
        p_h1 = mk(24'h000001, 56'h0, 56'h0, 56'h0, 56'h0);
        p_s2 = mk(24'h0, 56'h0, 56'h0, 56'h1, 56'h0);
        pa   = mk(24'hA5C30F, 56'h0123456789ABCD, 56'hFEDCBA98765432, 56'h00FF00FF00FF00, 56'h80000000000001);
        pb   = mk(24'h3C5A96, 56'hFFFFFFFFFFFFFF, 56'h0, 56'h5555555555AAAA, 56'h13579BDF02468A);
        px   = mk(24'h112233, 56'hDEADBEEF012345, 56'h1, 56'h2, 56'h3);
        py   = mk(24'h800000, 56'h0, 56'hC0FFEE00C0FFEE, 56'h0, 56'h7);

        present();
        repeat (3) @(posedge clk_pixel);
        #1;
        chk("rst_ready", pkt_ready, 0);
        chk("rst_outputs", {out_valid, pkt_done, pkt_abort, ch0_hdr_bit, ch0_not_first, ch1_data, ch2_data}, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", pkt_ready, 1);

        // Null fill with nothing pending
        isl_q = {pn};
        island(32);
        repeat (2) tick();

        // Header LSB only: header parity 8'h4A
        offer_q.push_back(p_h1); present(); tick();
        chk("ready_low_pending", pkt_ready, 0);
        isl_q = {p_h1};
        island(32);
        repeat (2) tick();

        // Subpacket 2 bit 0 only
        offer_q.push_back(p_s2); present(); tick();
        isl_q = {p_s2};
        island(32);
        repeat (2) tick();

        // Back-to-back: B waits until A is loaded at cycle 0
        offer_q.push_back(pa); offer_q.push_back(pb); present(); tick();
        chk("ready_low_b_wait", pkt_ready, 0);
        tick();
        chk("ready_still_low", pkt_ready, 0);
        isl_q = {pa, pb};
        island(64);
        chk("b_accepted", offer_q.size(), 0);
        repeat (2) tick();

        // Abort at cnt 10; Y stays pending and goes out in the next island
        offer_q.push_back(px); offer_q.push_back(py); present(); tick();
        isl_q = {px};
        island(10);
        exp_aborts++;
        repeat (3) tick();
        chk("ready_low_y_pending", pkt_ready, 0);
        isl_q = {py};
        island(32);
        repeat (3) tick();

        chk("scoreboard_drained", exp_q.size(), 0);
        chk("scoreboard0_drained", exp0_q.size(), 0);
        chk("aborts_seen", exp_aborts, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
